// File: rtl/laser_tx_sequencer_if.sv
// Host, transmitter, receiver and status signals of the laser TX sequencer.
// master = host/link side, slave = sequencer side.
interface laser_tx_sequencer_if;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RETRY_W = 2;

  logic               host_valid;
  logic [WORD_W-1:0]  host_data;
  logic               host_last;
  logic               host_ready;
  logic [BYTE_W-1:0]  tx_data1;
  logic [BYTE_W-1:0]  tx_data2;
  logic               tx_data_ready;
  logic               tx_en;
  logic               tx_done;
  logic               rx_valid;
  logic [BYTE_W-1:0]  rx_data;
  logic               busy;
  logic               pkt_sent;
  logic               pkt_error;
  logic [RETRY_W-1:0] retry_ct;

  modport master (
    output host_valid, host_data, host_last, tx_done, rx_valid, rx_data,
    input  host_ready, tx_data1, tx_data2, tx_data_ready, tx_en,
           busy, pkt_sent, pkt_error, retry_ct
  );

  modport slave (
    input  host_valid, host_data, host_last, tx_done, rx_valid, rx_data,
    output host_ready, tx_data1, tx_data2, tx_data_ready, tx_en,
           busy, pkt_sent, pkt_error, retry_ct
  );
endinterface

// File: rtl/laser_tx_sequencer.sv
// Buffers a host packet, sends header/length/data byte pairs to the laser TX and
// retries on NAK/timeout. Define LASER_TX_CSUM_EN to append a per-lane XOR checksum.
module laser_tx_sequencer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TIMEOUT   = 40,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  laser_tx_sequencer_if.slave  bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned RTY_W  = 2;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BYTE_W-1:0] HDR_BYTE  = 8'hCC;
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h11;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RETRY_MAX = RTY_W'(MAX_RETRY);

`ifdef LASER_TX_CSUM_EN
  typedef enum logic [2:0] {
    IDLE, FILL, SEND_HDR, SEND_LEN, SEND_DATA, SEND_CSUM, WAIT_ACK
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, FILL, SEND_HDR, SEND_LEN, SEND_DATA, WAIT_ACK
  } state_e;
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    ptr_q, ptr_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic                host_ready_q, host_ready_d;
  logic [BYTE_W-1:0]   tx_d1_q, tx_d1_d;
  logic [BYTE_W-1:0]   tx_d2_q, tx_d2_d;
  logic                tx_rdy_q, tx_rdy_d;
  logic                tx_en_q, tx_en_d;
  logic                busy_q, busy_d;
  logic                sent_q, sent_d;
  logic                err_q, err_d;
`ifdef LASER_TX_CSUM_EN
  logic [BYTE_W-1:0]   csum1_q, csum1_d;
  logic [BYTE_W-1:0]   csum2_q, csum2_d;
`endif

  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic                accept_c;
  logic                timeout_c;
  logic                send_c;
  logic [WORD_W-1:0]   rd_word_c;

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[IDX_W'(count_q)] <= bus.host_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      ptr_q        <= '0;
      to_q         <= '0;
      retry_q      <= '0;
      host_ready_q <= 1'b1;
      tx_d1_q      <= '0;
      tx_d2_q      <= '0;
      tx_rdy_q     <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      sent_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef LASER_TX_CSUM_EN
      csum1_q      <= '0;
      csum2_q      <= '0;
`endif
    end else begin
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      to_q         <= to_d;
      retry_q      <= retry_d;
      host_ready_q <= host_ready_d;
      tx_d1_q      <= tx_d1_d;
      tx_d2_q      <= tx_d2_d;
      tx_rdy_q     <= tx_rdy_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      sent_q       <= sent_d;
      err_q        <= err_d;
`ifdef LASER_TX_CSUM_EN
      csum1_q      <= csum1_d;
      csum2_q      <= csum2_d;
`endif
    end
  end

  // Next state, counters and packet-level pulses.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    retry_d   = retry_q;
    sent_d    = 1'b0;
    err_d     = 1'b0;
    accept_c  = bus.host_valid && host_ready_q;
    timeout_c = (to_q == TO_LAST);

    case (state_q)
      IDLE, FILL: begin
        if (accept_c) begin
          count_d = count_q + CNT_W'(1);
          if (bus.host_last || (count_d == DEPTH_C)) begin
            state_d = SEND_HDR;
          end else begin
            state_d = FILL;
          end
        end
      end
      SEND_HDR: begin
        if (bus.tx_done) state_d = SEND_LEN;
      end
      SEND_LEN: begin
        if (bus.tx_done) begin
          state_d = SEND_DATA;
          ptr_d   = '0;
        end
      end
      SEND_DATA: begin
        if (bus.tx_done) begin
          if (ptr_q == (count_q - CNT_W'(1))) begin
`ifdef LASER_TX_CSUM_EN
            state_d = SEND_CSUM;
`else
            state_d = WAIT_ACK;
`endif
          end else begin
            ptr_d = ptr_q + CNT_W'(1);
          end
        end
      end
`ifdef LASER_TX_CSUM_EN
      SEND_CSUM: begin
        if (bus.tx_done) state_d = WAIT_ACK;
      end
`endif
      WAIT_ACK: begin
        // A response in the timeout cycle is judged on its content.
        if (bus.rx_valid && (bus.rx_data == ACK_BYTE)) begin
          sent_d  = 1'b1;
          count_d = '0;
          retry_d = '0;
          state_d = IDLE;
        end else if (bus.rx_valid || timeout_c) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = SEND_HDR;
          end else begin
            err_d   = 1'b1;
            count_d = '0;
            retry_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == WAIT_ACK) && (state_d == WAIT_ACK)) begin
      to_d = to_q + TO_W'(1);
    end else begin
      to_d = '0;
    end
  end

`ifdef LASER_TX_CSUM_EN
  // Running per-lane XOR of accepted payload, cleared when the packet retires.
  always_comb begin
    csum1_d = csum1_q;
    csum2_d = csum2_q;
    if (accept_c) begin
      csum1_d = csum1_q ^ bus.host_data[7:0];
      csum2_d = csum2_q ^ bus.host_data[15:8];
    end
    if (sent_d || err_d) begin
      csum1_d = '0;
      csum2_d = '0;
    end
  end
`endif

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    send_c    = 1'b0;
    tx_d1_d   = '0;
    tx_d2_d   = '0;
    rd_word_c = mem_q[IDX_W'(ptr_d)];

    case (state_d)
      SEND_HDR: begin
        send_c  = 1'b1;
        tx_d1_d = HDR_BYTE;
        tx_d2_d = HDR_BYTE;
      end
      SEND_LEN: begin
        send_c  = 1'b1;
        tx_d1_d = count_d;
        tx_d2_d = count_d;
      end
      SEND_DATA: begin
        send_c  = 1'b1;
        tx_d1_d = rd_word_c[7:0];
        tx_d2_d = rd_word_c[15:8];
      end
`ifdef LASER_TX_CSUM_EN
      SEND_CSUM: begin
        send_c  = 1'b1;
        tx_d1_d = csum1_q;
        tx_d2_d = csum2_q;
      end
`endif
      default: ;
    endcase

    tx_rdy_d     = send_c;
    tx_en_d      = send_c || (state_d == WAIT_ACK);
    busy_d       = (state_d != IDLE);
    host_ready_d = ((state_d == IDLE) || (state_d == FILL)) && (count_d < DEPTH_C);
  end

  assign bus.host_ready    = host_ready_q;
  assign bus.tx_data1      = tx_d1_q;
  assign bus.tx_data2      = tx_d2_q;
  assign bus.tx_data_ready = tx_rdy_q;
  assign bus.tx_en         = tx_en_q;
  assign bus.busy          = busy_q;
  assign bus.pkt_sent      = sent_q;
  assign bus.pkt_error     = err_q;
  assign bus.retry_ct      = retry_q;

endmodule

// File: tb/tb_laser_tx_sequencer.sv
// Scoreboard bench for laser_tx_sequencer: directed packets, expected byte pairs
// and packet pulses are queued by the stimulus and retired by a monitor.
module tb_laser_tx_sequencer;

  localparam logic [1:0] K_PAIR = 2'd1;
  localparam logic [1:0] K_SENT = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  laser_tx_sequencer_if ifc ();

  laser_tx_sequencer #(.DEPTH(16), .TIMEOUT(40), .MAX_RETRY(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int passes = 0;
  logic [17:0] exp_q[$];
  logic [15:0] pkt[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic sb_pop(input logic [17:0] act);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: unexpected output %h (kind/b1/b2), none expected", act);
    end else begin
      e = exp_q.pop_front();
      chk("scoreboard", 32'(act), 32'(e));
    end
  endtask

  task automatic push_pair(input logic [7:0] b1, input logic [7:0] b2);
    exp_q.push_back({K_PAIR, b1, b2});
  endtask

  // Expected transmit sequence for the words currently in pkt.
  task automatic exp_packet();
    logic [7:0] x1, x2;
    x1 = 8'h00;
    x2 = 8'h00;
    push_pair(8'hCC, 8'hCC);
    push_pair(8'(pkt.size()), 8'(pkt.size()));
    for (int i = 0; i < pkt.size(); i++) begin
      push_pair(pkt[i][7:0], pkt[i][15:8]);
      x1 = x1 ^ pkt[i][7:0];
      x2 = x2 ^ pkt[i][15:8];
    end
`ifdef LASER_TX_CSUM_EN
    push_pair(x1, x2);
`endif
  endtask

  task automatic write_word(input logic [15:0] d, input bit last);
    int n;
    n = 0;
    ifc.host_valid = 1'b1;
    ifc.host_data  = d;
    ifc.host_last  = last;
    while (ifc.host_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("host_accept_timeout", 32'(n), 32'(0));
    @(negedge clk);
    ifc.host_valid = 1'b0;
    ifc.host_last  = 1'b0;
  endtask

  task automatic send_packet(input bit use_last);
    for (int i = 0; i < pkt.size(); i++) begin
      write_word(pkt[i], use_last && (i == pkt.size() - 1));
    end
  endtask

  task automatic wait_ack_state();
    int n;
    n = 0;
    while (!(ifc.tx_en === 1'b1 && ifc.tx_data_ready === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_ack", 32'(n < 2000), 32'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifc.busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", 32'(n < 2000), 32'(1));
  endtask

  task automatic rx_now(input logic [7:0] b);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    @(negedge clk);
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
  endtask

  // Transmitter model: tx_done three cycles after each pair is presented.
  initial begin
    int n;
    n = 0;
    ifc.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.tx_data_ready === 1'b1 && rst === 1'b0) begin
        n++;
        if (n == 3) begin
          ifc.tx_done = 1'b1;
          n = 0;
        end else begin
          ifc.tx_done = 1'b0;
        end
      end else begin
        ifc.tx_done = 1'b0;
        n = 0;
      end
    end
  end

  // Monitor: retires completed pairs and pulses, and checks pair stability.
  initial begin
    bit pv, pd;
    logic [15:0] pp;
    pv = 1'b0;
    pd = 1'b0;
    pp = '0;
    forever begin
      @(negedge clk);
      #2;
      if (ifc.tx_data_ready === 1'b1 && pv && !pd)
        chk("pair_hold", 32'({ifc.tx_data2, ifc.tx_data1}), 32'(pp));
      if (ifc.tx_data_ready === 1'b1 && ifc.tx_done === 1'b1)
        sb_pop({K_PAIR, ifc.tx_data1, ifc.tx_data2});
      if (ifc.pkt_sent === 1'b1)  sb_pop({K_SENT, 16'h0000});
      if (ifc.pkt_error === 1'b1) sb_pop({K_ERR, 16'h0000});
      pv = (ifc.tx_data_ready === 1'b1);
      pd = (ifc.tx_done === 1'b1);
      pp = {ifc.tx_data2, ifc.tx_data1};
    end
  end

  initial begin
    int n;
    rst            = 1'b1;
    ifc.host_valid = 1'b0;
    ifc.host_data  = '0;
    ifc.host_last  = 1'b0;
    ifc.rx_valid   = 1'b0;
    ifc.rx_data    = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", 32'(ifc.tx_en), 32'(0));
    chk("rst_tx_data_ready", 32'(ifc.tx_data_ready), 32'(0));
    chk("rst_tx_data", 32'({ifc.tx_data1, ifc.tx_data2}), 32'(0));
    chk("rst_busy", 32'(ifc.busy), 32'(0));
    chk("rst_pulses", 32'({ifc.pkt_sent, ifc.pkt_error}), 32'(0));
    chk("rst_retry_ct", 32'(ifc.retry_ct), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("host_ready_after_rst", 32'(ifc.host_ready), 32'(1));

    // Three-word packet, acknowledged.
    pkt.delete();
    pkt.push_back(16'h0201); pkt.push_back(16'h0403); pkt.push_back(16'h0605);
    exp_packet();
    exp_q.push_back({K_SENT, 16'h0000});
    send_packet(1'b1);
    wait_ack_state();
    chk("retry_ct_first_send", 32'(ifc.retry_ct), 32'(0));
    rx_now(8'h11);
    chk("busy_after_ack", 32'(ifc.busy), 32'(0));
    chk("host_ready_after_ack", 32'(ifc.host_ready), 32'(1));

    // Sixteen words with no last flag: buffer full triggers the send.
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back({8'(2 * i + 1), 8'(2 * i)});
    exp_packet();
    exp_q.push_back({K_SENT, 16'h0000});
    send_packet(1'b0);
    chk("host_ready_full", 32'(ifc.host_ready), 32'(0));
    rx_now(8'hBB);
    chk("rx_ignored_in_send", 32'({ifc.tx_data_ready, ifc.retry_ct}), 32'({1'b1, 2'd0}));
    wait_ack_state();
    rx_now(8'h11);
    wait_idle();

    // One word, no response: three timed-out retries then drop.
    pkt.delete();
    pkt.push_back(16'hA55A);
    repeat (4) exp_packet();
    exp_q.push_back({K_ERR, 16'h0000});
    send_packet(1'b1);
    for (int r = 0; r < 4; r++) begin
      wait_ack_state();
      n = 0;
      while (ifc.tx_en === 1'b1 && ifc.tx_data_ready === 1'b0 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("wait_ack_cycles", 32'(n), 32'(40));
      if (r < 3) begin
        chk("retry_ct_timeout", 32'(ifc.retry_ct), 32'(r + 1));
      end else begin
        chk("busy_after_drop", 32'(ifc.busy), 32'(0));
        chk("retry_ct_after_drop", 32'(ifc.retry_ct), 32'(0));
      end
    end

    // NAK then ACK.
    pkt.delete();
    pkt.push_back(16'h3344); pkt.push_back(16'h5566);
    exp_packet();
    exp_packet();
    exp_q.push_back({K_SENT, 16'h0000});
    send_packet(1'b1);
    wait_ack_state();
    rx_now(8'hBB);
    chk("resend_after_nak", 32'({ifc.tx_data_ready, ifc.tx_data1, ifc.tx_data2}),
        32'({1'b1, 8'hCC, 8'hCC}));
    chk("retry_ct_after_nak", 32'(ifc.retry_ct), 32'(1));
    wait_ack_state();
    rx_now(8'h11);
    chk("retry_ct_after_ack", 32'(ifc.retry_ct), 32'(0));
    chk("busy_after_nak_ack", 32'(ifc.busy), 32'(0));

    // ACK arriving in the timeout cycle wins.
    pkt.delete();
    pkt.push_back(16'h0077);
    exp_packet();
    exp_q.push_back({K_SENT, 16'h0000});
    send_packet(1'b1);
    wait_ack_state();
    repeat (39) @(negedge clk);
    rx_now(8'h11);
    chk("ack_on_timeout_idle", 32'({ifc.busy, ifc.tx_data_ready}), 32'(0));
    repeat (5) @(negedge clk);
    chk("ack_on_timeout_stays_idle", 32'(ifc.busy), 32'(0));

    // Reset in the middle of the data phase.
    pkt.delete();
    pkt.push_back(16'h1111); pkt.push_back(16'h2222); pkt.push_back(16'h3333);
    push_pair(8'hCC, 8'hCC);
    push_pair(8'h03, 8'h03);
    send_packet(1'b1);
    n = 0;
    while (!(ifc.tx_data_ready === 1'b1 && ifc.tx_data1 === 8'h11) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_send_data", 32'(n < 500), 32'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'({ifc.tx_en, ifc.tx_data_ready, ifc.busy}), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("no_output_after_rst", 32'(exp_q.size()), 32'(0));
    chk("host_ready_after_mid_rst", 32'(ifc.host_ready), 32'(1));

    pkt.delete();
    pkt.push_back(16'h0A0B); pkt.push_back(16'h0C0D);
    exp_packet();
    exp_q.push_back({K_SENT, 16'h0000});
    send_packet(1'b1);
    wait_ack_state();
    rx_now(8'h11);
    wait_idle();

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
